// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction sequencer slice.
package spi_pkg;

    localparam int BYTE_W    = 8;
    localparam int SEL_MAX_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } state_t;

    // Request as seen on the upstream bus; sel is zero-extended to SEL_MAX_W.
    typedef struct packed {
        logic [BYTE_W-1:0]    data;
        logic [SEL_MAX_W-1:0] sel;
    } req_t;

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Request, response and SPI-master handshake signals of the sequencer.
interface spi_txn_sequencer_if #(parameter int SEL_W = 1);
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [BYTE_W-1:0] req_data;
    logic [SEL_W-1:0]  req_sel;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [BYTE_W-1:0] rsp_data;
    logic              rsp_err;

    logic              spi_start;
    logic [BYTE_W-1:0] spi_data_in;
    logic [SEL_W-1:0]  spi_slave_select;
    logic              spi_done;
    logic [BYTE_W-1:0] spi_data_out;

    logic              busy;

    modport slave (
        input  req_valid, req_data, req_sel, rsp_ready, spi_done, spi_data_out,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               spi_start, spi_data_in, spi_slave_select, busy
    );

    modport master (
        output req_valid, req_data, req_sel, rsp_ready, spi_done, spi_data_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               spi_start, spi_data_in, spi_slave_select, busy
    );

endinterface

// File: rtl/spi_req_fifo.sv
// Synchronous request FIFO; extra pointer MSB distinguishes full from empty.
module spi_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/spi_txn_sequencer.sv
// Buffers byte requests and issues them one at a time to the SPI master,
// with a chip-select gap after each response and a completion timeout.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int SEL_W      = 1,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    spi_txn_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } entry_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              done_q;
    logic [BYTE_W-1:0] data_in_q, data_in_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [BYTE_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    entry_t push_ent, pop_ent;
    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic   completion;

    assign push_ent   = '{data: bus.req_data, sel: bus.req_sel};
    assign fifo_push  = bus.req_valid && !fifo_full;
    // Only a rising edge counts, so a done level left high from earlier is ignored.
    assign completion = bus.spi_done && !done_q;

    spi_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_ent),
        .rdata (pop_ent),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tmo_q      <= '0;
            gap_q      <= '0;
            done_q     <= 1'b0;
            data_in_q  <= '0;
            sel_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            done_q     <= bus.spi_done;
            data_in_q  <= data_in_d;
            sel_q      <= sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (completion || tmo_q == TMO_LAST) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = 1'b0;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        data_in_d  = data_in_q;
        sel_d      = sel_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    data_in_d = pop_ent.data;
                    sel_d     = pop_ent.sel;
                end
            end
            ST_ISSUE: tmo_d = '0;
            ST_WAIT: begin
                if (completion) begin
                    rsp_data_d = bus.spi_data_out;
                    rsp_err_d  = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RESP:  if (bus.rsp_ready) gap_d = '0;
            ST_GAP:   if (gap_q != GAP_LAST) gap_d = gap_q + GW'(1);
            default: ;
        endcase
    end

    always_comb begin
        bus.req_ready        = !fifo_full;
        bus.spi_start        = (state_q == ST_ISSUE);
        bus.rsp_valid        = (state_q == ST_RESP);
        bus.busy             = (state_q != ST_IDLE) || !fifo_empty;
        bus.spi_data_in      = data_in_q;
        bus.spi_slave_select = sel_q;
        bus.rsp_data         = rsp_data_q;
        bus.rsp_err          = rsp_err_q;
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Randomised scoreboard bench: request/SPI/response monitors plus a master model.
module tb_spi_txn_sequencer;
    import spi_pkg::*;

    localparam int DEPTH  = 4;
    localparam int SEL_W  = 1;
    localparam int G      = 4;
    localparam int TB_TMO = 32;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         c;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    spi_txn_sequencer_if #(.SEL_W(SEL_W)) bus ();

    spi_txn_sequencer #(
        .DEPTH      (DEPTH),
        .SEL_W      (SEL_W),
        .GAP_CYCLES (G),
        .TIMEOUT    (TB_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode per request: 0 random done, 1 never done, 2 stale-high done, 3 fixed 16 clk / 0x3C
    int   cfg_q [$];
    req_t exp_req [$];
    rsp_t exp_rsp [$];

    int         occ, last_hs, last_acc, start_cyc, start_count;
    bit         inflight, have_hs, pend_at_hs, rsp_hold, prev_start;
    logic [7:0] rh_data, hold_data;
    logic       rh_err;
    logic [SEL_W-1:0] hold_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mwait(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // Monitor: request acceptance, start/issue checks, response scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            exp_req.delete();
            exp_rsp.delete();
            cfg_q.delete();
            occ = 0; inflight = 0; have_hs = 0; rsp_hold = 0; prev_start = 0;
        end else begin
            if (bus.spi_start) begin
                chk("start_one_cycle", prev_start, 0);
                chk("start_while_inflight", inflight, 0);
                chk("start_has_request", exp_req.size() != 0, 1);
                if (exp_req.size() != 0) begin
                    req_t r;
                    r = exp_req.pop_front();
                    chk("spi_data_in", bus.spi_data_in, r.data);
                    chk("spi_slave_select", SEL_MAX_W'(bus.spi_slave_select), r.sel);
                end
                if (have_hs) begin
                    chk("gap_min", (cyc - last_hs) >= G + 2, 1);
                    if (pend_at_hs) chk("gap_exact", cyc - last_hs, G + 2);
                end
                occ--;
                inflight  = 1;
                start_cyc = cyc;
                start_count++;
                hold_data = bus.spi_data_in;
                hold_sel  = bus.spi_slave_select;
            end else if (inflight) begin
                chk("spi_data_in_hold", bus.spi_data_in, hold_data);
                chk("spi_sel_hold", bus.spi_slave_select, hold_sel);
            end
            prev_start = bus.spi_start;

            chk("req_ready", bus.req_ready, occ < DEPTH);
            chk("busy", bus.busy, (occ > 0) || inflight || (have_hs && (cyc - last_hs) <= G));

            if (bus.req_valid && bus.req_ready) begin
                exp_req.push_back('{data: bus.req_data, sel: SEL_MAX_W'(bus.req_sel)});
                occ++;
                last_acc = cyc;
            end

            if (bus.rsp_valid) begin
                if (!rsp_hold) begin
                    chk("rsp_expected", exp_rsp.size() != 0, 1);
                    if (exp_rsp.size() != 0) begin
                        rsp_t e;
                        e = exp_rsp.pop_front();
                        chk("rsp_data", bus.rsp_data, e.d);
                        chk("rsp_err", bus.rsp_err, e.e);
                        chk("rsp_latency_cycle", cyc, e.c);
                    end
                    rh_data  = bus.rsp_data;
                    rh_err   = bus.rsp_err;
                    rsp_hold = 1;
                end else begin
                    chk("rsp_data_stable", bus.rsp_data, rh_data);
                    chk("rsp_err_stable", bus.rsp_err, rh_err);
                end
                if (bus.rsp_ready) begin
                    rsp_hold   = 0;
                    inflight   = 0;
                    have_hs    = 1;
                    last_hs    = cyc;
                    pend_at_hs = (occ > 0);
                end
            end else if (rsp_hold) begin
                chk("rsp_valid_held", bus.rsp_valid, 1);
                rsp_hold = 0;
            end
        end
    end

    // SPI master model: decides each transfer's outcome and predicts the response.
    initial begin
        int mode, k, L, S, w;
        logic [7:0] d;
        bit ab;
        bus.spi_done     = 1'b0;
        bus.spi_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.spi_done = 1'b0;
            end else if (bus.spi_start) begin
                mode = (cfg_q.size() > 0) ? cfg_q.pop_front() : 0;
                k = cyc;
                case (mode)
                    1: begin
                        exp_rsp.push_back('{8'h00, 1'b1, k + TB_TMO + 1});
                        mwait(TB_TMO + 1, ab);
                    end
                    2: begin
                        S = $urandom_range(3, 10);
                        d = 8'($urandom);
                        exp_rsp.push_back('{d, 1'b0, k + S + 3});
                        mwait(S, ab);
                        if (!ab) begin
                            bus.spi_done = 1'b0;
                            mwait(2, ab);
                        end
                        if (!ab) begin
                            bus.spi_done     = 1'b1;
                            bus.spi_data_out = d;
                            w = $urandom_range(1, 3);
                            mwait(w, ab);
                        end
                        bus.spi_done = 1'b0;
                    end
                    default: begin
                        L = (mode == 3) ? 16 : $urandom_range(2, 20);
                        d = (mode == 3) ? 8'h3C : 8'($urandom);
                        exp_rsp.push_back('{d, 1'b0, k + L + 1});
                        mwait(L, ab);
                        if (!ab) begin
                            bus.spi_done     = 1'b1;
                            bus.spi_data_out = d;
                            w = $urandom_range(1, 3);
                            mwait(w, ab);
                        end
                        bus.spi_done     = 1'b0;
                        bus.spi_data_out = 8'($urandom);
                    end
                endcase
            end else if (cfg_q.size() > 0 && cfg_q[0] == 2) begin
                bus.spi_done = 1'b1;
            end
        end
    end

    task automatic push(input logic [7:0] d, input logic [SEL_W-1:0] s, input int m);
        bit acc;
        acc = 1'b0;
        cfg_q.push_back(m);
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_sel   = s;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge clk);
            acc = bus.req_ready;
            tick();
        end
        bus.req_valid = 1'b0;
        if (!acc) chk("push_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            ok = !bus.busy && !bus.rsp_valid && exp_req.size() == 0 && exp_rsp.size() == 0;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_start(input int s0);
        for (int i = 0; i < 500 && start_count <= s0; i++) tick();
        if (start_count <= s0) chk("start_timeout", 0, 1);
    endtask

    bit push_done;

    initial begin
        int s0, m;
        start_count   = 0;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_spi_start", bus.spi_start, 0);
        chk("rst_spi_data_in", bus.spi_data_in, 0);
        chk("rst_spi_sel", bus.spi_slave_select, 0);
        chk("rst_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Single transaction, fixed master timing, plus accept-to-start latency.
        bus.rsp_ready = 1'b1;
        s0 = start_count;
        push(8'hA5, 1'b0, 3);
        wait_start(s0);
        chk("accept_to_start", start_cyc - last_acc, 2);
        wait_idle();

        // Fill and order with consumer always ready.
        for (int i = 1; i <= 5; i++) push(8'(i), SEL_W'(i % 2), 0);
        wait_idle();

        // Timeout followed by a normal request.
        push(8'h77, 1'b1, 1);
        push(8'h88, 1'b0, 0);
        wait_idle();

        // Response stall with the FIFO driven to full.
        bus.rsp_ready = 1'b0;
        s0 = start_count;
        fork
            for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i), SEL_W'(i % 2), 0);
            begin
                repeat (60) tick();
                chk("stall_rsp_valid", bus.rsp_valid, 1);
                chk("stall_no_second_start", start_count - s0, 1);
                chk("stall_fifo_full", bus.req_ready, 0);
                bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Stale done held high across ISSUE.
        push(8'h5A, 1'b1, 2);
        wait_idle();

        // Randomised traffic with random consumer back-pressure.
        push_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    m = $urandom_range(0, 9);
                    push(8'($urandom), SEL_W'($urandom), (m < 7) ? 0 : (m == 7) ? 1 : 2);
                    repeat ($urandom_range(0, 6)) tick();
                end
                push_done = 1'b1;
            end
            begin
                while (!push_done) begin
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                bus.rsp_ready = 1'b1;
            end
        join
        wait_idle();

        // Reset in the middle of WAIT with a second request still queued.
        s0 = start_count;
        push(8'h11, 1'b0, 1);
        push(8'h22, 1'b1, 0);
        wait_start(s0);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        chk("midrst_spi_start", bus.spi_start, 0);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_req_ready", bus.req_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        s0 = start_count;
        repeat (20) tick();
        chk("postrst_no_start", start_count - s0, 0);
        chk("postrst_busy", bus.busy, 0);
        chk("postrst_req_ready", bus.req_ready, 1);

        chk("exp_rsp_drained", exp_rsp.size(), 0);
        chk("exp_req_drained", exp_req.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
